// File: rtl/quant_clamp_pipe_pkg.sv
// Shared widths and helpers for the quantise/clamp pipeline.
// Lane data is packed with lane 0 in the LSBs.
package quant_clamp_pipe_pkg;

    localparam int LANES_DEF  = 4;
    localparam int AB_BW_DEF  = 21;
    localparam int D_BW_DEF   = 8;
    localparam int SH_BW_DEF  = 5;
    localparam int CNT_BW_DEF = 16;

    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_LO   = 2'd1,
        CLAMP_HI   = 2'd2
    } clamp_sel_e;

    function automatic int packed_w(int lanes, int bw);
        return lanes * bw;
    endfunction

    // Shifting by AB_BW or more gives the same result as shifting by AB_BW.
    function automatic int eff_shift(int sh, int ab_bw);
        return (sh >= ab_bw) ? ab_bw : sh;
    endfunction

endpackage

// File: rtl/quant_clamp_pipe_if.sv
// Beat interface of the quantise/clamp pipeline: input beat with its
// per-beat config, output beat, and the saturation-counter controls.
interface quant_clamp_pipe_if
    import quant_clamp_pipe_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int AB_BW  = AB_BW_DEF,
    parameter int D_BW   = D_BW_DEF,
    parameter int SH_BW  = SH_BW_DEF,
    parameter int CNT_BW = CNT_BW_DEF
) ();

    logic                               i_valid;
    logic                               o_ready;
    logic [packed_w(LANES, AB_BW)-1:0]  i_acc_bias;
    logic [SH_BW-1:0]                   i_shift;
    logic                               i_relu_en;
    logic [D_BW-1:0]                    i_min_value;
    logic [D_BW-1:0]                    i_max_value;
    logic                               o_valid;
    logic                               i_ready;
    logic [packed_w(LANES, D_BW)-1:0]   o_data;
    logic                               i_clr_cnt;
    logic [CNT_BW-1:0]                  o_sat_cnt;

    modport slave (
        input  i_valid, i_acc_bias, i_shift, i_relu_en, i_min_value, i_max_value,
        input  i_ready, i_clr_cnt,
        output o_ready, o_valid, o_data, o_sat_cnt
    );

    modport master (
        output i_valid, i_acc_bias, i_shift, i_relu_en, i_min_value, i_max_value,
        output i_ready, i_clr_cnt,
        input  o_ready, o_valid, o_data, o_sat_cnt
    );

endinterface

// File: rtl/quant_clamp_lane.sv
// One lane: round-half-up arithmetic shift into S1, clamp into S2.
// Stage load enables come from the shared handshake in the top.
module quant_clamp_lane
    import quant_clamp_pipe_pkg::*;
#(
    parameter int AB_BW = AB_BW_DEF,
    parameter int D_BW  = D_BW_DEF,
    parameter int SH_BW = SH_BW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_s1_i,
    input  logic                    ld_s2_i,
    input  logic signed [AB_BW-1:0] x_i,
    input  logic        [SH_BW-1:0] shift_i,
    input  logic                    relu_en_i,
    input  logic signed [D_BW-1:0]  min_i,
    input  logic signed [D_BW-1:0]  max_i,
    output logic                    sat_o,
    output logic signed [D_BW-1:0]  data_o
);

    // One extra bit so adding the rounding constant never wraps.
    localparam int RW = AB_BW + 1;

    logic signed [RW-1:0]   xe;
    logic signed [RW-1:0]   rnd;
    logic signed [RW-1:0]   sum;
    logic signed [RW-1:0]   r_d, r_q;
    logic signed [RW-1:0]   lo_x, max_x;
    logic signed [D_BW-1:0] lo;
    logic signed [D_BW-1:0] d_d, d_q;
    clamp_sel_e             sel;
    int                     sh_e;

    always_comb begin
        sh_e = eff_shift(int'(shift_i), AB_BW);
        xe   = {x_i[AB_BW-1], x_i};
        rnd  = (sh_e == 0) ? '0 : (RW'(1) << (sh_e - 1));
        sum  = xe + rnd;
        r_d  = sum >>> sh_e;
    end

    always_comb begin
        lo    = (relu_en_i && min_i[D_BW-1]) ? '0 : min_i;
        lo_x  = {{(RW - D_BW){lo[D_BW-1]}}, lo};
        max_x = {{(RW - D_BW){max_i[D_BW-1]}}, max_i};
        sel   = CLAMP_NONE;
        // Lower bound wins when the bounds are inverted.
        if (r_q < lo_x) begin
            sel = CLAMP_LO;
        end else if (r_q > max_x) begin
            sel = CLAMP_HI;
        end
        case (sel)
            CLAMP_LO: d_d = lo;
            CLAMP_HI: d_d = max_i;
            default:  d_d = r_q[D_BW-1:0];
        endcase
        sat_o = (sel != CLAMP_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            d_q <= '0;
        end else begin
            if (ld_s1_i) begin
                r_q <= r_d;
            end
            if (ld_s2_i) begin
                d_q <= d_d;
            end
        end
    end

    assign data_o = d_q;

endmodule

// File: rtl/quant_clamp_pipe.sv
// Two-stage quantise/clamp pipeline over LANES lanes with a shared
// valid/ready handshake and a sticky saturated-lane counter.
module quant_clamp_pipe
    import quant_clamp_pipe_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int AB_BW  = AB_BW_DEF,
    parameter int D_BW   = D_BW_DEF,
    parameter int SH_BW  = SH_BW_DEF,
    parameter int CNT_BW = CNT_BW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    quant_clamp_pipe_if.slave bus
);

    logic                             adv;
    logic                             ld_s1;
    logic                             ld_s2;
    logic                             v1_d, v1_q;
    logic                             v2_d, v2_q;
    logic                             relu1_d, relu1_q;
    logic signed [D_BW-1:0]           min1_d, min1_q;
    logic signed [D_BW-1:0]           max1_d, max1_q;
    logic [CNT_BW-1:0]                cnt_d, cnt_q;
    logic [CNT_BW:0]                  cnt_sum;
    logic [LANES-1:0]                 sat;
    logic [packed_w(LANES, D_BW)-1:0] lane_d;
    int                               nsat;

    // The whole pipe moves together; o_ready never looks at i_valid.
    assign adv   = !v2_q || bus.i_ready;
    assign ld_s1 = adv && bus.i_valid;
    assign ld_s2 = adv && v1_q;

    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        relu1_d = relu1_q;
        min1_d  = min1_q;
        max1_d  = max1_q;
        if (adv) begin
            v1_d = bus.i_valid;
            v2_d = v1_q;
        end
        if (ld_s1) begin
            relu1_d = bus.i_relu_en;
            min1_d  = bus.i_min_value;
            max1_d  = bus.i_max_value;
        end
    end

    always_comb begin
        nsat = 0;
        for (int l = 0; l < LANES; l++) begin
            if (sat[l]) begin
                nsat++;
            end
        end
        cnt_sum = {1'b0, cnt_q} + (CNT_BW + 1)'(nsat);
        cnt_d   = cnt_q;
        if (bus.i_clr_cnt) begin
            cnt_d = '0;
        end else if (ld_s2) begin
            cnt_d = cnt_sum[CNT_BW] ? '1 : cnt_sum[CNT_BW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            relu1_q <= 1'b0;
            min1_q  <= '0;
            max1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            relu1_q <= relu1_d;
            min1_q  <= min1_d;
            max1_q  <= max1_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        quant_clamp_lane #(
            .AB_BW (AB_BW),
            .D_BW  (D_BW),
            .SH_BW (SH_BW)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .ld_s1_i   (ld_s1),
            .ld_s2_i   (ld_s2),
            .x_i       (bus.i_acc_bias[l*AB_BW +: AB_BW]),
            .shift_i   (bus.i_shift),
            .relu_en_i (relu1_q),
            .min_i     (min1_q),
            .max_i     (max1_q),
            .sat_o     (sat[l]),
            .data_o    (lane_d[l*D_BW +: D_BW])
        );
    end

    assign bus.o_ready   = adv;
    assign bus.o_valid   = v2_q;
    assign bus.o_data    = lane_d;
    assign bus.o_sat_cnt = cnt_q;

endmodule

// File: doc/quant_clamp_pipe.md
QUANT_CLAMP_PIPE -- requirements
Module: quant_clamp_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel lanes.
REQ-002 SHALL have parameter AB_BW, default 21: signed accumulator+bias width per lane.
REQ-003 SHALL have parameter D_BW, default 8: signed output width per lane.
REQ-004 SHALL have parameter SH_BW, default 5: shift-amount width.
REQ-005 SHALL have parameter CNT_BW, default 16: saturation-counter width.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 i_valid  in  1  input beat valid.
REQ-009 o_ready  out  1  block can accept an input beat.
REQ-010 i_acc_bias  in  LANES*AB_BW  packed signed lanes; lane 0 in LSBs.
REQ-011 i_shift  in  SH_BW  arithmetic right-shift amount, sampled with the beat.
REQ-012 i_relu_en  in  1  1: effective lower bound is max(0, i_min_value); sampled with the beat.
REQ-013 i_min_value / i_max_value  in  D_BW each  signed clamp bounds; sampled with the beat.
REQ-014 o_valid  out  1  output beat valid.
REQ-015 i_ready  in  1  downstream accepts output beat.
REQ-016 o_data  out  LANES*D_BW  packed signed clamped lanes.
REQ-017 i_clr_cnt  in  1  synchronous clear of o_sat_cnt.
REQ-018 o_sat_cnt  out  CNT_BW  count of saturated lanes since reset/clear.

Function
REQ-019 Transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
REQ-020 Two-stage pipeline: S1 = shift+round, S2 = clamp; latency exactly 2 cycles from input transfer to o_valid with no stall.
REQ-021 Pipeline advances when S2 empty or i_ready; o_ready = advance; o_ready SHALL NOT depend combinationally on i_valid.
REQ-022 Full throughput: one beat per cycle when i_ready held 1; no beat dropped or duplicated under any stall pattern.
REQ-023 S1 per lane: r = (x + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed at AB_BW+1 bits (round half-up, no wrap at max positive x).
REQ-024 Shift values >= AB_BW SHALL saturate to AB_BW.
REQ-025 Bounds, shift and relu_en travel with their beat; changes mid-stall SHALL NOT affect beats already accepted.
REQ-026 S2 per lane, with lo = relu_en ? max(0,min) : min: r<lo -> lo; else r>max -> max; else r truncated to D_BW (exact since in range).
REQ-027 If lo > max, comparison order of REQ-026 applies (r<lo gives lo, else max).
REQ-028 A lane counts as saturated when either clamp branch is taken.
REQ-029 o_sat_cnt adds the beat's saturated-lane count at S2 load; sticks at all-ones; i_clr_cnt has priority over same-cycle increment.
REQ-030 o_data and o_valid SHALL be held stable while o_valid & !i_ready.

Reset
REQ-031 On rst_n low: both stage valids 0, o_valid 0, o_data 0, o_sat_cnt 0, stored configs 0; o_ready = 1 after release.
REQ-032 Reset mid-operation discards all in-flight beats; no output beat emitted for them.

Structure
REQ-033 Shared package holds the default widths (AB_BW, D_BW, SH_BW, CNT_BW) and the lane pack/unpack width rule.
REQ-034 One sub-module, quant_clamp_lane, SHALL implement a single lane's round/shift and clamp, instantiated LANES times; handshake and counter stay in the top.

Verification
REQ-035 Defaults, shift 0, min -64, max 63, relu 0, lanes {100,-100,63,-64} -> {63,-64,63,-64} after 2 cycles, o_sat_cnt=2.
REQ-036 shift 4, lanes {24,23,-24,-25}, bounds -128/127 -> {2,1,-1,-2} (round half-up), sat_cnt unchanged.
REQ-037 relu 1, min -64, max 63, lanes {-5,0,5,200} -> {0,0,5,63}, sat_cnt +2.
REQ-038 Stream 20 beats with random i_ready toggling -> outputs in order, bit-exact to model, none lost/duplicated, held stable while stalled.
REQ-039 i_clr_cnt asserted in the cycle a beat with 3 saturated lanes loads S2 -> o_sat_cnt = 0; with CNT_BW=4 preloaded to 14 plus 3 saturations -> 15.
REQ-040 Assert rst_n low with 2 beats in flight -> o_valid 0, o_data 0 immediately; no stale beat appears after release.
